// File: rtl/mem_access_unit_if.sv
// Bus bundle between control/ALU, mem_access_unit and RAM.
// slave = the unit itself, master = the side driving requests and RAM data.
interface mem_access_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              start;
  logic              rw;
  logic              ifetch;
  logic [1:0]        dt;
  logic              sign;
  logic [DATA_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_moc;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_mov;
  logic              mem_rw;
  logic [1:0]        mem_dt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] ir;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, rw, ifetch, dt, sign,
    input  addr_in, wdata, mem_rdata, mem_moc,
    output mem_addr, mem_wdata, mem_mov,
    output mem_rw, mem_dt, mar, mdr, ir,
    output busy, done, err
  );

  modport master (
    output start, rw, ifetch, dt, sign,
    output addr_in, wdata, mem_rdata, mem_moc,
    input  mem_addr, mem_wdata, mem_mov,
    input  mem_rw, mem_dt, mar, mdr, ir,
    input  busy, done, err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Clocked MAR/MDR/IR with MOV/MOC handshake, alignment check, read extension.
// Optional ACCESS watchdog enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              clr,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] ir_q;
  logic              rw_q;
  logic [1:0]        dt_q;
  logic              sign_q;
  logic              if_q;
  logic              err_q;

  logic              accept;
  logic              fetch_rd;
  logic [1:0]        dt_eff;
  logic              misalign;
  logic              complete;
  logic              expire;

  assign accept   = (state_q == IDLE) && bus.start;
  assign fetch_rd = bus.ifetch && bus.rw;

  always_comb begin
    dt_eff = bus.dt;
    if (fetch_rd || bus.dt == 2'b11) dt_eff = 2'b10;
  end

  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      dt_eff == 2'b01: misalign = bus.addr_in[0];
      dt_eff == 2'b10: misalign = |bus.addr_in[1:0];
      default:         misalign = 1'b0;
    endcase
  end

  assign complete = (state_q == ACCESS) && bus.mem_moc;

`ifdef MAU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  // Last waiting cycle is TIMEOUT-1 so ACCESS lasts exactly TIMEOUT cycles.
  assign expire = (state_q == ACCESS) && !bus.mem_moc &&
                  (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) cnt_q <= '0;
    else if (state_q == SETUP) cnt_q <= '0;
    else if (state_q == ACCESS && !bus.mem_moc) cnt_q <= cnt_q + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] extend(
    input logic [DATA_W-1:0] d,
    input logic [1:0]        t,
    input logic              s
  );
    logic [DATA_W-1:0] r;
    r = d;
    case (t)
      2'b00:   r = {{(DATA_W-8){s & d[7]}}, d[7:0]};
      2'b01:   r = {{(DATA_W-16){s & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.start) state_d = misalign ? DONE : SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: if (complete || expire) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mar_q  <= '0;
      mdr_q  <= '0;
      ir_q   <= '0;
      rw_q   <= 1'b0;
      dt_q   <= 2'b00;
      sign_q <= 1'b0;
      if_q   <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      mar_q  <= bus.addr_in[ADDR_W-1:0];
      rw_q   <= bus.rw;
      dt_q   <= dt_eff;
      sign_q <= bus.sign;
      if_q   <= fetch_rd;
      err_q  <= misalign;
      if (!bus.rw && !misalign) mdr_q <= bus.wdata;
    end else if (complete) begin
      if (rw_q && if_q)  ir_q  <= bus.mem_rdata;
      if (rw_q && !if_q) mdr_q <= extend(bus.mem_rdata, dt_q, sign_q);
    end else if (expire) begin
      err_q <= 1'b1;
    end
  end

  assign bus.mar       = mar_q;
  assign bus.mdr       = mdr_q;
  assign bus.ir        = ir_q;
  assign bus.mem_addr  = mar_q;
  assign bus.mem_wdata = mdr_q;
  assign bus.mem_rw    = rw_q;
  assign bus.mem_dt    = dt_q;
  assign bus.mem_mov   = (state_q == ACCESS);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;

endmodule
